// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle for the multicycle controller.
// master: controller side (consumes IR fields / flags, drives enables and selects).
// slave : datapath side (drives IR fields / flags, consumes enables and selects).
interface multicycle_control_if;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned PCSRC_W = 2;
  localparam int unsigned STATE_W = 4;

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [SRCB_W-1:0]  alu_src_b;
  logic [ALU_W-1:0]   alu_select;
  logic [PCSRC_W-1:0] pc_src;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_select, pc_src, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_select, pc_src, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, plus the ALU operation decoder.
// Ports: clk, rst_n (async, active low); bus (master modport) carrying
// opcode/funct/zero/mem_ready in and all enables, mux selects, alu_select,
// illegal_op and the debug state out.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    IMM_EX   = 4'd8,
    IMM_WB   = 4'd9,
    BEQ      = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  state_t     state_q;
  logic       funct_legal;
  logic       op_legal;
  logic [2:0] r_alu;
  logic [2:0] imm_alu;

  // R-type funct to ALU code
  always_comb begin
    r_alu       = ALU_ADD;
    funct_legal = 1'b1;
    case (bus.funct)
      6'b100000: r_alu = ALU_ADD;
      6'b100010: r_alu = ALU_SUB;
      6'b100100: r_alu = ALU_AND;
      6'b100101: r_alu = ALU_OR;
      default:   funct_legal = 1'b0;
    endcase
  end

  // Immediate-op ALU code and overall instruction legality
  always_comb begin
    imm_alu = ALU_ADD;
    case (bus.opcode)
      OP_ANDI: imm_alu = ALU_AND;
      OP_ORI:  imm_alu = ALU_OR;
      default: imm_alu = ALU_ADD;
    endcase
    case (bus.opcode)
      OP_R:                                             op_legal = funct_legal;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_legal = 1'b1;
      default:                                          op_legal = 1'b0;
    endcase
  end

  // State register with next-state selection; unused codes fall back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      case (state_q)
        FETCH:    if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          if (!op_legal) begin
            state_q <= FETCH;
          end else begin
            case (bus.opcode)
              OP_LW, OP_SW:              state_q <= MEMADR;
              OP_R:                      state_q <= RTYPE_EX;
              OP_BEQ:                    state_q <= BEQ;
              OP_ADDI, OP_ANDI, OP_ORI:  state_q <= IMM_EX;
              OP_J:                      state_q <= JUMP;
              default:                   state_q <= FETCH;
            endcase
          end
        end
        MEMADR:   state_q <= (bus.opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:    if (bus.mem_ready) state_q <= MEMWB;
        MEMWB:    state_q <= FETCH;
        MEMWR:    if (bus.mem_ready) state_q <= FETCH;
        RTYPE_EX: state_q <= RTYPE_WB;
        RTYPE_WB: state_q <= FETCH;
        IMM_EX:   state_q <= IMM_WB;
        IMM_WB:   state_q <= FETCH;
        BEQ:      state_q <= FETCH;
        JUMP:     state_q <= FETCH;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Output decode from state; pc_en/ir_write also follow mem_ready/zero.
  // Strobes are gated off while reset is held (state already reads FETCH).
  always_comb begin
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_select = 3'b000;
    bus.pc_src     = 2'b00;
    bus.illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_read   = 1'b1;
        bus.alu_src_b  = 2'b01;
        bus.alu_select = ALU_ADD;
        bus.ir_write   = bus.mem_ready;
        bus.pc_en      = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b  = 2'b11;
        bus.alu_select = ALU_ADD;
        bus.illegal_op = ~op_legal;
      end
      MEMADR: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.alu_select = ALU_ADD;
      end
      MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      RTYPE_EX: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_select = r_alu;
      end
      RTYPE_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      IMM_EX: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.alu_select = imm_alu;
      end
      IMM_WB: begin
        bus.reg_write = 1'b1;
      end
      BEQ: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_select = ALU_CMP;
        bus.pc_src     = 2'b01;
        bus.pc_en      = bus.zero;
      end
      JUMP: begin
        bus.pc_src = 2'b10;
        bus.pc_en  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      bus.pc_en      = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_write  = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: reset behaviour, directed
// instruction runs and a randomized instruction stream, each judged by
// per-instruction expectations (latency, strobe counts, execute/writeback
// selects) derived from the instruction class.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_if bus ();

  multicycle_control #(.RESET_STATE(4'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_IMM = 4, C_J = 5, C_ILL = 6;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b100000 || fn == 6'b100010 ||
                         fn == 6'b100100 || fn == 6'b100101) ? C_R : C_ILL;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b001000, 6'b001100, 6'b001101: return C_IMM;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  // Base latency with memory always ready
  function automatic int base_len(input int cls);
    case (cls)
      C_LW:         return 5;
      C_SW, C_R, C_IMM: return 4;
      C_BEQ, C_J:   return 3;
      default:      return 2;
    endcase
  endfunction

  // ALU operation the execute cycle should show
  function automatic logic [2:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: case (fn)
                   6'b100010: return 3'b011;
                   6'b100100: return 3'b111;
                   6'b100101: return 3'b001;
                   default:   return 3'b010;
                 endcase
      6'b001100: return 3'b111;
      6'b001101: return 3'b001;
      6'b000100: return 3'b110;
      default:   return 3'b010;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting in FETCH. fw = FETCH stall cycles,
  // mw = memory stall cycles (lw/sw), zf = forced zero value or -1 for random.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int zf);
    int cls, len, ex, mem_start;
    int n_pc, n_ir, n_rw, n_mw, n_mr, n_ill, n_fetch, n_conf;
    logic zb, rw_last, rd_last, m2r_last, pc_ex;
    logic [2:0] sel_ex;
    logic [1:0] srcb_ex, pcsrc_ex;
    cls = classify(op, fn);
    len = base_len(cls) + fw + ((cls == C_LW || cls == C_SW) ? mw : 0);
    ex = fw + 2;
    mem_start = fw + 3;
    n_pc = 0; n_ir = 0; n_rw = 0; n_mw = 0; n_mr = 0; n_ill = 0; n_fetch = 0; n_conf = 0;
    zb = 1'b0; rw_last = 1'b0; rd_last = 1'b0; m2r_last = 1'b0; pc_ex = 1'b0;
    sel_ex = 3'b000; srcb_ex = 2'b00; pcsrc_ex = 2'b00;
    for (int c = 0; c <= len; c++) begin
      @(negedge clk);
      bus.opcode = op;
      bus.funct  = fn;
      bus.zero   = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      bus.mem_ready = 1'b1;
      if (c < fw) bus.mem_ready = 1'b0;
      if ((cls == C_LW || cls == C_SW) && c >= mem_start && c < mem_start + mw)
        bus.mem_ready = 1'b0;
      if (c == len) bus.mem_ready = 1'b0;  // park in FETCH for the next run
      #1;
      if (c < len) begin
        n_pc    += int'(bus.pc_en);
        n_ir    += int'(bus.ir_write);
        n_rw    += int'(bus.reg_write);
        n_mw    += int'(bus.mem_write);
        n_mr    += int'(bus.mem_read);
        n_ill   += int'(bus.illegal_op);
        n_fetch += (bus.state == 4'd0) ? 1 : 0;
        n_conf  += int'(bus.reg_write & bus.mem_write);
        if (c == ex) begin
          zb = bus.zero; sel_ex = bus.alu_select; srcb_ex = bus.alu_src_b;
          pcsrc_ex = bus.pc_src; pc_ex = bus.pc_en;
        end
        if (c == len - 1) begin
          rw_last = bus.reg_write; rd_last = bus.reg_dst; m2r_last = bus.mem_to_reg;
        end
      end else begin
        chk("back_to_fetch", 32'(bus.state), 32'd0);
      end
    end
    chk("fetch_cycles", 32'(n_fetch), 32'(fw + 1));
    chk("ir_write_cnt", 32'(n_ir), 32'd1);
    chk("pc_en_cnt", 32'(n_pc),
        32'(1 + ((cls == C_BEQ && zb) ? 1 : 0) + ((cls == C_J) ? 1 : 0)));
    chk("reg_write_cnt", 32'(n_rw), 32'((cls == C_LW || cls == C_R || cls == C_IMM) ? 1 : 0));
    chk("mem_write_cnt", 32'(n_mw), 32'((cls == C_SW) ? mw + 1 : 0));
    chk("mem_read_cnt", 32'(n_mr), 32'(fw + 1 + ((cls == C_LW) ? mw + 1 : 0)));
    chk("illegal_cnt", 32'(n_ill), 32'((cls == C_ILL) ? 1 : 0));
    chk("rw_mw_overlap", 32'(n_conf), 32'd0);
    if (cls != C_ILL && cls != C_J) begin
      chk("alu_select_ex", 32'(sel_ex), 32'(exp_alu(op, fn)));
      chk("alu_src_b_ex", 32'(srcb_ex),
          32'((cls == C_R || cls == C_BEQ) ? 2'b00 : 2'b10));
    end
    if (cls == C_BEQ) begin
      chk("beq_pc_src", 32'(pcsrc_ex), 32'd1);
      chk("beq_pc_en", 32'(pc_ex), 32'(zb));
    end
    if (cls == C_J) begin
      chk("j_pc_src", 32'(pcsrc_ex), 32'd2);
      chk("j_pc_en", 32'(pc_ex), 32'd1);
    end
    if (cls == C_LW || cls == C_R || cls == C_IMM) begin
      chk("wb_reg_write", 32'(rw_last), 32'd1);
      chk("wb_reg_dst", 32'(rd_last), 32'((cls == C_R) ? 1 : 0));
      chk("wb_mem_to_reg", 32'(m2r_last), 32'((cls == C_LW) ? 1 : 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [5:0] ops [10];
  logic [5:0] fns [5];

  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
            6'b001100, 6'b001101, 6'b000010, 6'b111111, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000111};

    // Reset held: FETCH selects, strobes off
    rst_n = 1'b0;
    bus.opcode = 6'b100011; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
    chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
    chk("rst_alu_src_b", 32'(bus.alu_src_b), 32'd1);
    chk("rst_alu_select", 32'(bus.alu_select), 32'd2);

    // Release, run lw into MEMRD, then reset asynchronously mid-access
    @(negedge clk);
    rst_n = 1'b1; bus.mem_ready = 1'b1;
    #1;
    chk("lw_fetch_pc_en", 32'(bus.pc_en), 32'd1);
    repeat (3) @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("memrd_state_nz", 32'(bus.state != 4'd0), 32'd1);
    chk("memrd_mem_read", 32'(bus.mem_read), 32'd1);
    chk("memrd_iord", 32'(bus.iord), 32'd1);
    #1;
    rst_n = 1'b0; bus.mem_ready = 1'b1;
    #1;
    chk("async_state", 32'(bus.state), 32'd0);
    chk("async_mem_read", 32'(bus.mem_read), 32'd0);
    chk("async_pc_en", 32'(bus.pc_en), 32'd0);
    chk("async_ir_write", 32'(bus.ir_write), 32'd0);
    chk("async_iord", 32'(bus.iord), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_state", 32'(bus.state), 32'd0);
    chk("release_pc_en", 32'(bus.pc_en), 32'd1);
    chk("release_ir_write", 32'(bus.ir_write), 32'd1);
    bus.mem_ready = 1'b0;  // hold in FETCH before the directed runs

    // Directed: lw, sw with 3 wait cycles, R sweep, beq both ways, j, illegal
    run_instr(6'b100011, 6'b000000, 0, 0, -1);
    run_instr(6'b101011, 6'b000000, 0, 3, -1);
    for (int i = 0; i < 4; i++) run_instr(6'b000000, fns[i], 0, 0, -1);
    run_instr(6'b000100, 6'b000000, 0, 0, 1);
    run_instr(6'b000100, 6'b000000, 0, 0, 0);
    run_instr(6'b000010, 6'b000000, 0, 0, -1);
    run_instr(6'b111111, 6'b000000, 0, 0, -1);
    run_instr(6'b000000, 6'b000111, 0, 0, -1);
    run_instr(6'b001100, 6'b000000, 1, 0, -1);
    run_instr(6'b100011, 6'b000000, 2, 2, -1);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
